// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared widths, FSM encoding and skid depth for the FIFO burst drain
// Contents:
//   DATA_W     byte width of FIFO read data and stream data
//   CNT_W      width of the FIFO occupancy count (0..64)
//   SKID_DEPTH entries in the output skid buffer
//   state_e    drain FSM states
package fifo_drain_pkg;

  localparam int DATA_W     = 8;
  localparam int CNT_W      = 7;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/stream_skid2.sv
// rtl/stream_skid2.sv - two-entry valid/ready skid buffer carrying a byte plus first/last tags
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid          capture in_data/in_first/in_last this cycle (caller guarantees space)
//   in_data           byte to capture
//   in_first, in_last burst framing tags travelling with the byte
//   occ               current occupancy (0..2)
//   out_valid         head entry present
//   out_ready         downstream accepts the head entry
//   out_data          head byte
//   out_first         head tag, qualified by out_valid
//   out_last          head tag, qualified by out_valid
module stream_skid2
  import fifo_drain_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic [1:0]        occ,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last
);

  localparam int ENT_W = DATA_W + 2;

  // Entry layout: {data, first, last}; ent0 is always the head.
  logic [ENT_W-1:0] ent0_q, ent0_d;
  logic [ENT_W-1:0] ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop;
  logic [1:0]       wr_idx;

  assign pop    = (occ_q != 2'd0) && out_ready;
  // Incoming byte lands in the first slot that is free after this cycle's pop.
  assign wr_idx = occ_q - {1'b0, pop};

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q - {1'b0, pop} + {1'b0, in_valid};
    if (pop) begin
      ent0_d = ent1_q;
    end
    if (in_valid) begin
      if (wr_idx == 2'd0) begin
        ent0_d = {in_data, in_first, in_last};
      end else begin
        ent1_d = {in_data, in_first, in_last};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = ent0_q[ENT_W-1:2];
  assign out_first = out_valid & ent0_q[1];
  assign out_last  = out_valid & ent0_q[0];

endmodule

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - pops the circular FIFO and emits bursts on a valid/ready byte stream
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   enable      allows a new burst to start (looked at in IDLE only)
//   flush       level; drains a short burst when count < BURST_LEN
//   count       FIFO occupancy, the only source of emptiness
//   buf_out     FIFO read data, valid the cycle after read_en
//   read_en     FIFO pop request
//   out_data    stream byte
//   out_valid   stream valid
//   out_ready   stream ready
//   out_first   first byte of a burst
//   out_last    last byte of a burst
//   busy        high while a burst is in progress
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] buf_out,
  output logic              read_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_iss_q, rem_iss_d;
  logic [CNT_W-1:0] rem_out_q, rem_out_d;
  logic             inflight_q, inflight_d;
  logic             first_iss_q, first_iss_d;  // next read issued is the burst's first byte
  logic             tag_first_q, tag_first_d;  // tags of the byte currently in flight
  logic             tag_last_q, tag_last_d;

  logic [1:0]       occ;
  logic             pop;
  logic             start;
  logic [CNT_W-1:0] start_len;
  logic [2:0]       credit_used;
  logic [2:0]       credit_cap;

  assign pop = out_valid & out_ready;

  // A full-length burst takes priority over a flush of a partial FIFO.
  always_comb begin
    start     = 1'b0;
    start_len = BURST_LEN_C;
    if (enable) begin
      if (count >= BURST_LEN_C) begin
        start     = 1'b1;
        start_len = BURST_LEN_C;
      end else if (flush && (count != '0)) begin
        start     = 1'b1;
        start_len = count;
      end
    end
  end

  // A read needs a skid slot for when its data arrives next cycle: held bytes
  // plus the one in flight, less the one leaving now, must stay below depth.
  assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
  assign credit_cap  = 3'(SKID_DEPTH) + {2'b00, pop};
  assign read_en     = (state_q == BURST) && (rem_iss_q != '0) && (count != '0)
                       && (credit_used < credit_cap);

  always_comb begin
    state_d     = state_q;
    rem_iss_d   = rem_iss_q;
    rem_out_d   = rem_out_q;
    first_iss_d = first_iss_q;
    inflight_d  = read_en;
    tag_first_d = tag_first_q;
    tag_last_d  = tag_last_q;

    // Framing is decided at issue time; order is preserved through the skid,
    // so the read issued with one byte left is the byte delivered last.
    if (read_en) begin
      rem_iss_d   = rem_iss_q - CNT_W'(1);
      tag_first_d = first_iss_q;
      tag_last_d  = (rem_iss_q == CNT_W'(1));
      first_iss_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = BURST;
          rem_iss_d   = start_len;
          rem_out_d   = start_len;
          first_iss_d = 1'b1;
        end
      end
      BURST: begin
        if (pop && (rem_out_q != '0)) begin
          rem_out_d = rem_out_q - CNT_W'(1);
          if (rem_out_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_iss_q   <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
      first_iss_q <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_iss_q   <= rem_iss_d;
      rem_out_q   <= rem_out_d;
      inflight_q  <= inflight_d;
      first_iss_q <= first_iss_d;
      tag_first_q <= tag_first_d;
      tag_last_q  <= tag_last_d;
    end
  end

  stream_skid2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_data   (buf_out),
    .in_first  (tag_first_q),
    .in_last   (tag_last_q),
    .occ       (occ),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  assign busy = (state_q == BURST);

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - self-checking bench for fifo_burst_drain against a FIFO and stream model
`timescale 1ns/1ps
module tb_fifo_burst_drain;
  import fifo_drain_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              enable = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [CNT_W-1:0]  count = '0;
  logic [DATA_W-1:0] buf_out = '0;
  logic              read_en, out_valid, out_first, out_last, busy;
  logic [DATA_W-1:0] out_data;

  logic              enable1 = 1'b0, flush1 = 1'b0, out_ready1 = 1'b1;
  logic [CNT_W-1:0]  count1 = '0;
  logic [DATA_W-1:0] buf_out1 = 8'hA5;
  logic              read_en1, out_valid1, out_first1, out_last1, busy1;
  logic [DATA_W-1:0] out_data1;

  fifo_burst_drain #(.BURST_LEN(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .count(count),
    .buf_out(buf_out), .read_en(read_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last), .busy(busy)
  );

  fifo_burst_drain #(.BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .flush(flush1), .count(count1),
    .buf_out(buf_out1), .read_en(read_en1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_first(out_first1), .out_last(out_last1), .busy(busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // FIFO model: requests from the stimulus are sequence-numbered so only this
  // process ever modifies the FIFO contents.
  logic [7:0] fifo_q[$];
  int         pre_seq = 0, pre_seen = 0, pre_n = 0;
  logic [7:0] pre_base = 8'h00;
  int         clr_seq = 0, clr_seen = 0;
  int         ld1_seq = 0, ld1_seen = 0;
  int         auto_total = 0, auto_done = 0;
  logic [7:0] auto_base = 8'h00;
  int         rd_cnt = 0, beat_cnt = 0;

  always @(posedge clk) begin
    if (clr_seq != clr_seen) begin
      fifo_q.delete();
      clr_seen = clr_seq;
    end
    if (pre_seq != pre_seen) begin
      for (int i = 0; i < pre_n; i++) fifo_q.push_back(pre_base + 8'(i));
      pre_seen = pre_seq;
    end
    if (rst) begin
      rd_cnt   = 0;
      beat_cnt = 0;
    end else begin
      if (out_valid && out_ready) beat_cnt++;
      if (read_en) begin
        rd_cnt++;
        if (fifo_q.size() != 0) buf_out <= fifo_q.pop_front();
        if (auto_done < auto_total) begin
          fifo_q.push_back(auto_base + 8'(auto_done));
          auto_done++;
        end
      end
    end
    count <= CNT_W'(fifo_q.size());
    if (ld1_seq != ld1_seen) begin
      count1   <= CNT_W'(1);
      ld1_seen = ld1_seq;
    end else if (read_en1 && !rst) begin
      count1 <= count1 - CNT_W'(1);
    end
  end

  // Expected stream: bytes in write order, framed into bursts.
  beat_t exp_q[$];
  beat_t cur_e;
  bit    tput_chk = 1'b0;
  int    cyc = 0, last_pop_cyc = 0;
  bit    prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("outstanding_le_2", 32'((rd_cnt - beat_cnt) <= 2), 1);
      if (read_en) chk("read_fifo_nonempty", 32'(fifo_q.size() != 0), 1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_beat", {out_data, out_first, out_last}, prev_beat);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h expected no beat at %0t", out_data, $time);
        end else begin
          cur_e = exp_q.pop_front();
          chk("beat_data_first_last", {out_data, out_first, out_last}, cur_e);
          if (tput_chk && !cur_e.f) chk("one_byte_per_clock", cyc - last_pop_cyc, 1);
        end
        last_pop_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_data, out_first, out_last};
    end
  end

  int rdy_mode = 0;
  int tick_n   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    tick_n++;
    if (rdy_mode == 1) out_ready = ((tick_n % 4) == 0) || ((tick_n % 4) == 3);
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    pre_base = base;
    pre_n    = n;
    pre_seq++;
  endtask

  task automatic expect_burst(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({base + 8'(i), i == 0, i == len - 1});
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_data", out_data, 0);
    chk("rst1_valid", out_valid1, 0);
    chk("rst1_busy", busy1, 0);
    rst = 1'b0;

    // Two full bursts from 16 bytes.
    preload(8'h00, 16);
    expect_burst(8'h00, 8);
    expect_burst(8'h08, 8);
    tput_chk = 1'b1;
    enable   = 1'b1;
    wait_drain("t1_drain", 200);
    tput_chk = 1'b0;
    chk("t1_fifo_empty", count, 0);

    // Partial FIFO waits for flush.
    preload(8'h20, 5);
    repeat (20) begin
      tick();
      chk("t2_no_read", read_en, 0);
      chk("t2_not_busy", busy, 0);
    end
    expect_burst(8'h20, 5);
    flush = 1'b1;
    tick();
    chk("t2_busy_e0", busy, 1);
    chk("t2_read_e0", read_en, 1);
    chk("t2_no_valid_e0", out_valid, 0);
    tick();
    chk("t2_no_valid_e1", out_valid, 0);
    tick();
    chk("t2_valid_e2", out_valid, 1);
    chk("t2_data_e2", out_data, 8'h20);
    chk("t2_first_e2", out_first, 1);
    wait_drain("t2_drain", 100);
    flush = 1'b0;
    chk("t2_fifo_empty", count, 0);

    // Backpressure with ready pattern 1,0,0,1.
    rdy_mode = 1;
    preload(8'h30, 8);
    expect_burst(8'h30, 8);
    wait_drain("t3_drain", 300);
    rdy_mode  = 0;
    out_ready = 1'b1;

    // Single-byte bursts.
    ld1_seq++;
    tick();
    enable1 = 1'b1;
    tick();
    chk("t4_busy_e0", busy1, 1);
    chk("t4_read_e0", read_en1, 1);
    chk("t4_no_valid_e0", out_valid1, 0);
    enable1 = 1'b0;
    tick();
    chk("t4_no_valid_e1", out_valid1, 0);
    chk("t4_busy_e1", busy1, 1);
    chk("t4_no_reread", read_en1, 0);
    tick();
    chk("t4_valid", out_valid1, 1);
    chk("t4_data", out_data1, 8'hA5);
    chk("t4_first", out_first1, 1);
    chk("t4_last", out_last1, 1);
    chk("t4_busy_deliver", busy1, 1);
    tick();
    chk("t4_busy_after", busy1, 0);
    chk("t4_valid_after", out_valid1, 0);

    // Reset after three of eight bytes.
    preload(8'h50, 8);
    expect_burst(8'h50, 8);
    base = beat_cnt;
    n    = 0;
    while (beat_cnt < base + 3 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_three_delivered", beat_cnt - base, 3);
    rst = 1'b1;
    clr_seq++;
    exp_q.delete();
    tick();
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_first", out_first, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_read_en", read_en, 0);
    rst = 1'b0;
    preload(8'h60, 8);
    expect_burst(8'h60, 8);
    wait_drain("t5_drain", 200);

    // Writer keeps count at 8 while draining; 32 bytes total.
    tput_chk   = 1'b1;
    auto_base  = 8'h88;
    auto_total = 24;
    preload(8'h80, 8);
    for (int b = 0; b < 4; b++) expect_burst(8'h80 + 8'(8 * b), 8);
    wait_drain("t6_drain", 400);
    tput_chk = 1'b0;
    chk("t6_all_written", auto_done, 24);
    chk("t6_fifo_empty", count, 0);

    repeat (10) tick();
    chk("final_no_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
Downstream consumer of the 64-entry circular FIFO. Pops bytes with the FIFO's read_en/buf_out/count interface and presents them as a valid/ready byte stream framed into bursts with first/last markers. Absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer, so the stream runs at 1 byte/clock when out_ready is held high.

Parameters:
DATA_W, 8, byte width; equals FIFO buf_out width.
CNT_W, 7, width of FIFO count (0..64).
BURST_LEN, 8, bytes per normal burst; legal range 1..64.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
enable  in  1  allows new bursts to start; sampled in IDLE only.
flush  in  1  level; starts a short burst of all current FIFO contents when count < BURST_LEN.
count  in  CNT_W  FIFO occupancy (FIFO count output).
buf_out  in  DATA_W  FIFO read data, valid the cycle after read_en.
read_en  out  1  FIFO pop request.
out_data  out  DATA_W  stream data.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready.
out_first  out  1  first byte of burst, qualified by out_valid.
out_last  out  1  last byte of burst, qualified by out_valid.
busy  out  1  high in BURST state.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, read_en=0, out_valid=0, out_first=0, out_last=0, busy=0, out_data=0, skid empty, in-flight flag=0, counters=0. A reset during a burst abandons it; bytes already popped are discarded.
- Empty detection uses count only, never the FIFO's buffer_empty (that flag lags count by one cycle).
- IDLE -> BURST when enable=1 and either:
  - count >= BURST_LEN: burst length = BURST_LEN.
  - flush=1 and 0 < count < BURST_LEN: burst length = count sampled that cycle.
  - If both conditions hold, the BURST_LEN rule wins.
- The burst length is latched into a 7-bit remaining-to-issue counter (rem_iss) and a remaining-to-deliver counter (rem_out).
- In BURST, read_en=1 (combinational) when all hold: rem_iss != 0, count != 0, and occ + inflight - pop < 2.
  - occ = skid occupancy (0..2).
  - inflight = read issued the previous cycle.
  - pop = out_valid & out_ready.
- Each read_en decrements rem_iss. The byte is captured from buf_out into the skid on the following cycle (inflight 1 -> capture).
- Stream output is the skid head.
  - out_first=1 on the first byte delivered in a burst.
  - out_last=1 when rem_out == 1.
  - Each pop decrements rem_out.
  - out_data/out_valid/out_first/out_last hold stable while out_valid=1 and out_ready=0.
- BURST -> IDLE on the cycle the last byte pops. busy drops the next cycle. A new burst may start the cycle after entering IDLE; there is no back-to-back start in the same cycle.
- Burst of length 1: out_first=out_last=1 on the same beat.
- Simultaneous FIFO writes do not matter; count is the only occupancy source.
- count can drop to 0 mid-burst only via external misuse. In that case read_en stalls and the burst continues when count > 0.
- Throughput: with out_ready=1 and sufficient count, one read per cycle. First out_valid appears 2 cycles after the IDLE->BURST decision edge.
- Arithmetic: all counters CNT_W bits, no wrap. rem_iss and rem_out never decrement below 0.

Decomposition:
- Package fifo_drain_pkg:
  - DATA_W and CNT_W localparams.
  - state enum {IDLE, BURST}.
  - Skid depth constant = 2.
- Sub-module stream_skid2: 2-entry valid/ready skid buffer.
  - Ports: clk, rst, in_valid, in_data plus first/last tag, occ output, out_valid/out_ready/out_data.
- Top module holds the FSM, counters, credit logic and first/last tagging.

Test Plan:
- Fill FIFO with 0x00..0x0F (count=16), enable=1, out_ready=1 -> two bursts of 8. Bytes 0x00..0x07 then 0x08..0x0F; out_first on 0x00 and 0x08, out_last on 0x07 and 0x0F; 1 byte/clock within each burst; no read when count=0.
- count=5, flush=0, enable=1 -> no read_en for 20 cycles. Raise flush -> 5-byte burst with out_last on the 5th byte; FIFO count ends at 0; no underflow read.
- 8-byte burst with out_ready toggling 1,0,0,1 pattern -> data stable while stalled; skid never exceeds 2; read_en suppressed while occ + inflight = 2; byte order preserved.
- BURST_LEN=1, FIFO holds 0xA5 -> single beat with out_first=out_last=1; busy high exactly through delivery.
- Assert rst for one cycle mid-burst (after 3 of 8 bytes) -> next cycle all outputs 0 and state IDLE. With FIFO also reset and refilled with 8 bytes, the next burst starts cleanly with out_first on the new first byte.
- FIFO writing continuously while draining (count held at 8) -> continuous bursts, no duplicated or dropped bytes (scoreboard against write order).
